// File: rtl/fifo_read_drain.sv
// Read-side drain for the async FIFO: pops words into a 2-entry skid buffer and streams them out
// on a valid/ready port with optional burst framing. Define READ_DRAIN_STATS_EN for transfer/stall counters.
module fifo_read_drain #(
  parameter int DATASIZE = 8,
  parameter int LENSIZE  = 8
) (
  input  logic                r_clk,
  input  logic                r_rst,
  input  logic                rempty,
  input  logic [DATASIZE-1:0] rdata,
  output logic                r_inc,
  input  logic                enable,
  input  logic [LENSIZE-1:0]  burst_len,
  output logic [DATASIZE-1:0] m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                m_last,
  output logic                busy,
  output logic                burst_done,
`ifdef READ_DRAIN_STATS_EN
  output logic [31:0]         word_count,
  output logic [31:0]         stall_count,
`endif
  output logic [1:0]          dbg_state
);

  // Handshake: a word moves when m_valid & m_ready in the same cycle; once m_valid rises,
  // m_data/m_last are frozen until that transfer happens.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [LENSIZE-1:0] LEN_ONE = LENSIZE'(1);

  state_t              state_q, state_d;
  logic [DATASIZE-1:0] mem_q [2];
  logic                wr_ptr_q, rd_ptr_q;
  logic [1:0]          occ_q;
  logic                inflight_q;
  logic [LENSIZE-1:0]  len_q, issued_q, delivered_q;
  logic                pop, issue_limit, credit_ok, start;

  assign m_valid     = (occ_q != 2'd0);
  assign m_data      = mem_q[rd_ptr_q];
  assign pop         = m_valid & m_ready;
  assign issue_limit = (len_q != '0) && (issued_q == len_q);
  // A word popped this cycle frees its slot in time for a read issued now.
  assign credit_ok   = ({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
  assign m_last      = m_valid && (len_q != '0) && (delivered_q == (len_q - LEN_ONE));
  assign busy        = (state_q != IDLE);
  assign dbg_state   = state_q;

  always_comb begin
    state_d    = state_q;
    r_inc      = 1'b0;
    burst_done = 1'b0;
    start      = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = RUN;
          start   = 1'b1;
        end
      end
      RUN: begin
        r_inc = !rempty && credit_ok && !issue_limit;
        if (issue_limit || !enable) state_d = FLUSH;
      end
      FLUSH: begin
        if (occ_q == 2'd0 && !inflight_q) begin
          state_d    = IDLE;
          burst_done = (len_q != '0) && (delivered_q == len_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      state_q    <= IDLE;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= r_inc;
    end
  end

  // The word requested last cycle is on rdata now and lands in the tail slot.
  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (inflight_q) begin
        mem_q[wr_ptr_q] <= rdata;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({inflight_q, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      len_q       <= '0;
      issued_q    <= '0;
      delivered_q <= '0;
    end else if (start) begin
      len_q       <= burst_len;
      issued_q    <= '0;
      delivered_q <= '0;
    end else begin
      if (r_inc) issued_q    <= issued_q + LEN_ONE;
      if (pop)   delivered_q <= delivered_q + LEN_ONE;
    end
  end

  a_no_overflow: assert property (@(posedge r_clk) disable iff (!r_rst)
    !(inflight_q && !pop && occ_q == 2'd2));

`ifdef READ_DRAIN_STATS_EN
  logic [31:0] word_cnt_q, stall_cnt_q;

  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      word_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (pop && word_cnt_q != '1) word_cnt_q <= word_cnt_q + 32'd1;
      if (m_valid && !m_ready && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign word_count  = word_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: doc/fifo_read_drain.md
Name: fifo_read_drain

Overview:
- Read-side consumer for the async FIFO.
- Pops words from the FIFO read port (r_inc/rempty/rdata) in the read clock domain and presents them on a valid/ready output stream.
- Contains a 2-entry skid buffer that absorbs the FIFO's 1-cycle read latency.
- Optional burst framing: a counted burst with a last-word marker and a done pulse.

Parameters:
DATASIZE, 8, FIFO data width; also the m_data width
LENSIZE, 8, width of burst_len and of the internal issue/deliver counters

Ports:
r_clk  in  1  read-domain clock; all logic is on the rising edge
r_rst  in  1  asynchronous, active-low reset
rempty  in  1  FIFO empty flag (read domain)
rdata  in  DATASIZE  FIFO read data, valid the cycle after r_inc is asserted
r_inc  out  1  FIFO pop request
enable  in  1  start/continue draining
burst_len  in  LENSIZE  words per burst; 0 = continuous, no framing
m_data  out  DATASIZE  output data
m_valid  out  1  output data valid
m_ready  in  1  downstream accept
m_last  out  1  final word of burst; qualified by m_valid
busy  out  1  FSM not in IDLE
burst_done  out  1  one-cycle pulse when a burst completes

Behaviour:
- Reset (r_rst=0, async):
  - FSM=IDLE; buffer empty; inflight=0; counters=0.
  - m_valid, m_last, busy, burst_done, r_inc all 0; m_data=0.
- Handshakes:
  - Output transfer = m_valid & m_ready.
  - Once m_valid is high, m_data and m_last hold until the transfer.
  - m_valid never drops without a transfer, except on reset.
- Read latency:
  - An r_inc in cycle N captures rdata at the end of cycle N+1 into the buffer tail.
  - inflight is a 1-bit register = r_inc of the previous cycle.
- Credit rule: r_inc = (state==RUN) & !rempty & (occ + inflight - pop < 2) & !issue_limit.
  - occ = buffer entries (0..2); pop = current-cycle transfer.
  - r_inc is combinational from m_ready and rempty; this is intentional.
  - Sustains 1 word/cycle when m_ready stays high.
  - r_inc is never asserted while rempty=1.
- Buffer:
  - 2-entry FIFO; m_data/m_valid/m_last come from the head entry.
  - A capture and a pop in the same cycle are both honoured; occ is unchanged.
  - Overflow is impossible by the credit rule; an assertion flags it.
- Burst counters:
  - len_q is latched on the IDLE->RUN transition; later changes to burst_len are ignored until the next burst.
  - issued counts r_inc; issue_limit = (len_q!=0) & (issued==len_q).
  - delivered counts transfers.
  - m_last = (len_q!=0) & (delivered==len_q-1) on the head word.
  - With len_q=0: m_last is always 0, the counters wrap freely, and no burst_done occurs.
- FSM:
  - IDLE -> RUN when enable=1 (at least 1 cycle in IDLE); counters are cleared on entry.
  - RUN -> FLUSH when issue_limit=1 or enable=0; no further r_inc after that.
  - FLUSH -> IDLE when occ==0 & inflight==0.
  - burst_done pulses on the FLUSH->IDLE edge only if len_q!=0 and delivered==len_q.
  - If enable is still 1 in IDLE, a new burst starts next cycle.
- Boundaries:
  - FIFO empty mid-burst: stay in RUN, stall r_inc, hold m_valid low once the buffer drains; resume when rempty=0.
  - enable dropped mid-burst: the partial burst flushes, m_last never fires, no burst_done.
  - Reset mid-burst: everything clears immediately; buffered words are discarded.
  - burst_len=1: exactly one read, m_last=1 on that word.

Optional Feature:
READ_DRAIN_STATS_EN:
- When defined, adds outputs word_count[31:0] and stall_count[31:0], both reset to 0 and saturating at 2^32-1.
  - word_count increments on each transfer.
  - stall_count increments each cycle with m_valid=1 & m_ready=0.
- When undefined, these ports and their logic are absent and the rest of the behaviour is identical.

Test Plan:
- FIFO holds 0x11,0x22,0x33; enable=1, burst_len=3, m_ready=1:
  - r_inc high 3 consecutive cycles.
  - m_data 0x11,0x22,0x33 on consecutive cycles; m_last only with 0x33.
  - burst_done pulses once; busy returns 0.
- Same data, m_ready held 0 for 5 cycles then 1:
  - exactly 2 r_inc while stalled; m_data holds 0x11.
  - no data lost; third read issued after the first transfer.
- burst_len=4, FIFO has 2 words, 2 more written 10 cycles later:
  - 2 words out, r_inc idle while rempty=1.
  - remaining 2 delivered; m_last on the 4th word.
- burst_len=0, 100-word stream, random m_ready:
  - all 100 words delivered in order; m_last never 1; no burst_done.
- r_rst pulsed low mid-burst with 2 words buffered:
  - m_valid, r_inc, busy go 0 asynchronously.
  - after release, the FSM restarts from IDLE.
- enable dropped after 2 of 5 words issued:
  - 2 words delivered, no m_last, no burst_done; FSM reaches IDLE.
